// File: rtl/instr_memory_if.sv
// instr_memory_if: EXE/MEM input bus, MEM/WB output bus, forwarding and stall of the MEM stage
interface instr_memory_if;
    logic [71:0] exebus;
    logic [70:0] membus;
    logic [31:0] aluOutMem;
    logic [4:0] writeRegMem;
    logic regWriteMem;
    logic stallMem;
    modport master(output exebus, input membus, aluOutMem, writeRegMem, regWriteMem, stallMem);
    modport slave(input exebus, output membus, aluOutMem, writeRegMem, regWriteMem, stallMem);
endinterface

// File: rtl/instr_memory.sv
// instr_memory: MEM pipeline stage with word-addressed data RAM and parameterised wait states
module instr_memory #(
    parameter int ADDR_BITS = 8,
    parameter int MEM_WAIT = 0
) (
    input logic clock,
    input logic reset,
    instr_memory_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, stateNext;
    logic [3:0] cnt, cntNext;
    logic [31:0] ram [2**ADDR_BITS];
    logic [4:0] writeReg;
    logic [31:0] writeData, aluOut;
    logic memWrite, memtoReg, regWrite, access, hold;
    logic [ADDR_BITS-1:0] idx;
    assign {regWrite, memtoReg, memWrite, aluOut, writeData, writeReg} = bus.exebus;
    assign idx = aluOut[ADDR_BITS+1:2];
    assign access = memWrite | memtoReg;
    assign bus.aluOutMem = aluOut;
    assign bus.writeRegMem = writeReg;
    assign bus.regWriteMem = regWrite;
    assign bus.stallMem = hold;
    // an access is held until its final WAIT cycle, where cnt has run down to zero
    always_comb begin
        hold = access && MEM_WAIT != 0 && (state == IDLE || cnt != 4'd0);
        stateNext = hold ? WAIT : IDLE;
        cntNext = state == WAIT ? cnt - 4'd1 : 4'(MEM_WAIT - 1);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
        end else begin
            state <= stateNext;
            cnt <= cntNext;
        end
    end
    always_ff @(posedge clock) begin
        if (reset || hold) bus.membus <= '0;
        else bus.membus <= {regWrite, memtoReg, ram[idx], aluOut, writeReg};
    end
    always_ff @(posedge clock) begin
        if (!reset && memWrite && !hold) ram[idx] <= writeData;
    end
endmodule

// File: tb/tb_instr_memory.sv
// tb_instr_memory: transaction-level model drives two MEM stages (MEM_WAIT 0 and 2) and checks every cycle
module tb_instr_memory;
    localparam int WAITS [2] = '{0, 2};
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset [2];
    logic [71:0] eb [2];
    logic [70:0] mbOut [2];
    logic [31:0] aluFw [2];
    logic [4:0] wrFw [2];
    logic rwFw [2];
    logic stallOut [2];
    instr_memory_if b0();
    instr_memory_if b1();
    instr_memory #(.ADDR_BITS(8), .MEM_WAIT(0)) dut0(.clock(clock), .reset(reset[0]), .bus(b0.slave));
    instr_memory #(.ADDR_BITS(8), .MEM_WAIT(2)) dut1(.clock(clock), .reset(reset[1]), .bus(b1.slave));
    assign b0.exebus = eb[0];
    assign b1.exebus = eb[1];
    assign mbOut[0] = b0.membus;
    assign mbOut[1] = b1.membus;
    assign aluFw[0] = b0.aluOutMem;
    assign aluFw[1] = b1.aluOutMem;
    assign wrFw[0] = b0.writeRegMem;
    assign wrFw[1] = b1.writeRegMem;
    assign rwFw[0] = b0.regWriteMem;
    assign rwFw[1] = b1.regWriteMem;
    assign stallOut[0] = b0.stallMem;
    assign stallOut[1] = b1.stallMem;
    int checks = 0;
    int errors = 0;
    bit curValid [2] = '{0, 0};
    bit stallChk [2];
    logic expStall [2];
    logic [70:0] nextMb [2], curMb [2], nextMask [2], curMask [2];
    bit nextMbValid [2] = '{0, 0};
    bit curMbValid [2] = '{0, 0};
    logic [31:0] mem [2][256];
    bit known [2][256];
    task automatic chk(string name, int d, logic [70:0] got, logic [70:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h", name, d, got, exp);
        end
    endtask
    always @(posedge clock)
        for (int d = 0; d < 2; d++) begin
            curMb[d] <= nextMb[d];
            curMask[d] <= nextMask[d];
            curMbValid[d] <= nextMbValid[d];
        end
    always @(negedge clock)
        for (int d = 0; d < 2; d++) begin
            if (curValid[d]) begin
                if (stallChk[d]) chk("stall", d, 71'(stallOut[d]), 71'(expStall[d]));
                chk("forward", d, 71'({aluFw[d], wrFw[d], rwFw[d]}), 71'({eb[d][68:37], eb[d][4:0], eb[d][71]}));
            end
            if (curMbValid[d]) chk("membus", d, mbOut[d] & curMask[d], curMb[d] & curMask[d]);
        end
    function automatic logic [71:0] mk(logic rw, logic m2r, logic mw, logic [31:0] alu, logic [31:0] wd, logic [4:0] wr);
        return {rw, m2r, mw, alu, wd, wr};
    endfunction
    task automatic step(int d, logic rst, logic [71:0] e, bit sc, logic st, logic [70:0] mb, logic [70:0] mask);
        reset[d] = rst;
        eb[d] = e;
        stallChk[d] = sc;
        expStall[d] = st;
        curValid[d] = 1'b1;
        nextMb[d] = mb;
        nextMask[d] = mask;
        nextMbValid[d] = 1'b1;
        @(posedge clock);
        #1;
    endtask
    task automatic txn(int d, logic [71:0] e);
        int idx;
        logic [70:0] mask;
        idx = int'(e[46:39]);
        mask = '1;
        if (!known[d][idx]) mask[68:37] = '0;
        if (e[69] | e[70]) repeat (WAITS[d]) step(d, 1'b0, e, 1'b1, 1'b1, '0, '1);
        step(d, 1'b0, e, 1'b1, 1'b0, {e[71], e[70], mem[d][idx], e[68:37], e[4:0]}, mask);
        if (e[69]) begin
            mem[d][idx] = e[36:5];
            known[d][idx] = 1'b1;
        end
    endtask
    task automatic run(int d);
        int kind;
        repeat (2) step(d, 1'b1, '0, 1'b0, 1'b0, '0, '1);
        chk("lit_reset_membus", d, mbOut[d], '0);
        txn(d, mk(0, 0, 1, 32'h10, 32'hDEADBEEF, 0));
        txn(d, mk(1, 1, 0, 32'h10, 0, 5));
        chk("lit_load_deadbeef", d, mbOut[d], {1'b1, 1'b1, 32'hDEADBEEF, 32'h10, 5'd5});
        txn(d, mk(0, 0, 1, 32'h20, 32'h12345678, 0));
        txn(d, mk(1, 1, 0, 32'h20, 0, 9));
        chk("lit_load_12345678", d, 71'(mbOut[d][68:37]), 71'(32'h12345678));
        if (WAITS[d] >= 2) begin
            txn(d, mk(0, 0, 1, 32'h40, 32'h0, 0));
            step(d, 1'b0, mk(0, 0, 1, 32'h40, 32'hCAFEF00D, 0), 1'b1, 1'b1, '0, '1);
            step(d, 1'b1, mk(0, 0, 1, 32'h40, 32'hCAFEF00D, 0), 1'b1, 1'b1, '0, '1);
            chk("lit_reset_wait_membus", d, mbOut[d], '0);
            txn(d, '0);
            txn(d, mk(1, 1, 0, 32'h40, 0, 2));
            chk("lit_abandoned_store", d, 71'(mbOut[d][68:37]), 71'(32'h0));
        end
        txn(d, mk(0, 0, 1, 32'h404, 32'hA5A5A5A5, 0));
        txn(d, mk(1, 1, 0, 32'h004, 0, 1));
        chk("lit_wrap_004", d, 71'(mbOut[d][68:37]), 71'(32'hA5A5A5A5));
        txn(d, mk(1, 1, 0, 32'h007, 0, 1));
        chk("lit_wrap_007", d, 71'(mbOut[d][68:37]), 71'(32'hA5A5A5A5));
        txn(d, mk(1, 0, 0, 32'h55, 0, 3));
        chk("lit_alu_membus", d, 71'({mbOut[d][70:69], mbOut[d][36:0]}), 71'({2'b10, 32'h55, 5'd3}));
        txn(d, mk(0, 0, 1, 32'h8, 32'h1, 0));
        txn(d, mk(1, 1, 1, 32'h8, 32'h2, 4));
        chk("lit_both_prewrite", d, 71'(mbOut[d][68:37]), 71'(32'h1));
        txn(d, mk(1, 1, 0, 32'h8, 0, 4));
        chk("lit_both_written", d, 71'(mbOut[d][68:37]), 71'(32'h2));
        for (int i = 0; i < 256; i++) txn(d, mk(0, 0, 1, 32'(i << 2) | ($urandom & 32'hFFFF_FC03), $urandom, 0));
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 3));
            txn(d, mk(1'($urandom), kind[0], kind[1], $urandom, $urandom, 5'($urandom)));
        end
        curValid[d] = 1'b0;
        nextMbValid[d] = 1'b0;
        eb[d] = '0;
        repeat (2) @(posedge clock);
    endtask
    initial begin
        fork
            run(0);
            run(1);
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
